// File: rtl/mimo_pkg.sv
// ----------------------------------------------------------------------------
// mimo_pkg
// Shared constants, types and helpers for the 4x4 MIMO 16-QAM K-best detector.
// The detector works on the 8x8 real-valued decomposition, so each layer
// decides one PAM-4 symbol.
//   WL      word length of R, Y and PED
//   FRAC    fractional bits of R, Y and PED (1.0 = 1<<FRAC)
//   K       survivors per layer (only 4 supported)
//   PED_MAX unsigned PED saturation limit (2^WL-1)
// ----------------------------------------------------------------------------
package mimo_pkg;

  localparam int WL   = 16;
  localparam int FRAC = 10;
  localparam int K    = 4;

  // PAM-4 children per parent and children per layer.
  localparam int NSYM = 4;
  localparam int NCH  = K * NSYM;

  // Accumulator width: Y plus up to 7 terms of |3*R| plus |3*R0| stays well
  // inside WL+7 signed bits, so interference and error never wrap.
  localparam int EW = WL + 7;

  localparam logic [WL-1:0] PED_MAX = '1;

  typedef logic signed [EW-1:0] acc_t;
  typedef logic [WL-1:0]        ped_t;

  // Symbol code c maps to s = 2c-3.
  typedef enum logic [1:0] {
    SYM_M3 = 2'b00,
    SYM_M1 = 2'b01,
    SYM_P1 = 2'b10,
    SYM_P3 = 2'b11
  } sym_code_t;

  function automatic int sym_val(input logic [1:0] c);
    return 2 * int'(c) - 3;
  endfunction

  // x * s(c) using shift-add only; no generic multiplier.
  function automatic acc_t mul_sym(input logic signed [WL-1:0] x,
                                   input logic [1:0]           c);
    acc_t xe;
    acc_t x3;
    xe = acc_t'(x);
    x3 = (xe <<< 1) + xe;
    unique case (sym_code_t'(c))
      SYM_M3:  mul_sym = -x3;
      SYM_M1:  mul_sym = -xe;
      SYM_P1:  mul_sym = xe;
      default: mul_sym = x3;
    endcase
  endfunction

endpackage

// File: rtl/detector_stage_if.sv
// ----------------------------------------------------------------------------
// detector_stage_if
// Data bundle of one K-best detector layer (free-running, no handshake).
//   Rarr     N*WL       signed R row; word0 = diagonal, word i pairs with
//                       the symbol decided i layers earlier
//   Y        WL         signed rotated receive sample
//   PATH_in  K*2*(N-1)  surviving partial paths from the previous layer
//   PED_in   K*WL       unsigned PEDs of those paths
//   PATH_out K*2*N      survivors of this layer, slot 0 best
//   PED_out  K*WL       survivor PEDs, ascending
// master drives the inputs (previous layer / bench), slave is the stage.
// ----------------------------------------------------------------------------
interface detector_stage_if
  import mimo_pkg::*;
#(
  parameter int N = 2
);

  logic [N*WL-1:0]        Rarr;
  logic signed [WL-1:0]   Y;
  logic [K*2*(N-1)-1:0]   PATH_in;
  logic [K*WL-1:0]        PED_in;
  logic [K*2*N-1:0]       PATH_out;
  logic [K*WL-1:0]        PED_out;

  modport master (
    output Rarr, Y, PATH_in, PED_in,
    input  PATH_out, PED_out
  );

  modport slave (
    input  Rarr, Y, PATH_in, PED_in,
    output PATH_out, PED_out
  );

endinterface

// File: rtl/ped_unit.sv
// ----------------------------------------------------------------------------
// ped_unit
// Expands one parent path with all four PAM-4 symbols and returns the four
// child PEDs (combinational).
//   i_rarr  N*WL      R row, word0 = diagonal
//   i_y     WL        signed receive sample
//   i_path  2*(N-1)   parent symbol codes, slot j pairs with R word j+1
//   i_ped   WL        parent PED (unsigned)
//   o_ped   4*WL      child PED for code c at [c*WL +: WL], saturated
// ----------------------------------------------------------------------------
module ped_unit
  import mimo_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N*WL-1:0]      i_rarr,
  input  logic signed [WL-1:0] i_y,
  input  logic [2*(N-1)-1:0]   i_path,
  input  ped_t                 i_ped,
  output logic [NSYM*WL-1:0]   o_ped
);

  // Interference-cancelled sample b = Y - sum R[j+1]*s(slot j), full precision.
  acc_t w_b;

  always_comb begin
    // NOTE: combinational accumulation uses blocking '=' so each loop
    // iteration sees the previous partial sum; registers elsewhere use '<='.
    w_b = acc_t'(i_y);
    for (int j = 0; j < N - 1; j++) begin
      w_b = w_b - mul_sym($signed(i_rarr[(j+1)*WL +: WL]), i_path[2*j +: 2]);
    end
  end

  for (genvar c = 0; c < NSYM; c++) begin : g_child
    acc_t                   w_e;
    logic signed [2*EW-1:0] w_sq_full;
    logic [2*EW-1:0]        w_sq;
    logic [WL:0]            w_sum;

    assign w_e       = w_b - mul_sym($signed(i_rarr[WL-1:0]), 2'(c));
    assign w_sq_full = (2*EW)'(w_e) * (2*EW)'(w_e);
    // The square is non-negative, so the arithmetic shift is a plain floor.
    assign w_sq      = $unsigned(w_sq_full >>> FRAC);
    assign w_sum     = {1'b0, i_ped} + {1'b0, w_sq[WL-1:0]};
    // Saturate when the square alone exceeds WL bits or the add carries out.
    assign o_ped[c*WL +: WL] = (|w_sq[2*EW-1:WL] || w_sum[WL]) ? PED_MAX
                                                                : w_sum[WL-1:0];
  end

endmodule

// File: rtl/detector_stage.sv
// ----------------------------------------------------------------------------
// detector_stage
// One layer of the K-best detector: expands K parent paths by the 4 PAM-4
// symbols, computes 16 child PEDs and keeps the K best in ascending order.
// Two-stage free-running pipeline, latency 2 clocks.
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears every pipeline register
//   bus  detector_stage_if.slave (Rarr, Y, PATH_in, PED_in -> PATH_out, PED_out)
// ----------------------------------------------------------------------------
module detector_stage
  import mimo_pkg::*;
#(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             rst,
  detector_stage_if.slave  bus
);

  localparam int PW = 2 * (N - 1);     // parent path width
  localparam int OW = 2 * N;           // child path width
  localparam int RW = $clog2(NCH);     // rank width

  // --------------------------------------------------------------------------
  // Child expansion
  // --------------------------------------------------------------------------
  ped_t            w_child_ped  [NCH];
  logic [OW-1:0]   w_child_path [NCH];

  for (genvar p = 0; p < K; p++) begin : g_parent
    logic [NSYM*WL-1:0] w_peds;

    ped_unit #(.N(N)) u_ped (
      .i_rarr (bus.Rarr),
      .i_y    (bus.Y),
      .i_path (bus.PATH_in[p*PW +: PW]),
      .i_ped  (bus.PED_in[p*WL +: WL]),
      .o_ped  (w_peds)
    );

    for (genvar c = 0; c < NSYM; c++) begin : g_code
      assign w_child_ped[p*NSYM + c]  = w_peds[c*WL +: WL];
      assign w_child_path[p*NSYM + c] = {bus.PATH_in[p*PW +: PW], 2'(c)};
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: child PEDs and their full path tags
  // --------------------------------------------------------------------------
  ped_t            r_ped  [NCH];
  logic [OW-1:0]   r_path [NCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the tag/PED arrays are reset too, so a reset really flushes
      // in-flight vectors instead of letting stale children reach the output.
      for (int i = 0; i < NCH; i++) begin
        r_ped[i]  <= '0;
        r_path[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_ped[i]  <= w_child_ped[i];
        r_path[i] <= w_child_path[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Rank-count selection: rank = #smaller + #equal with lower index. Ranks are
  // unique, so the child with rank r lands in slot r and ties favour the
  // lower child index.
  // --------------------------------------------------------------------------
  logic [RW-1:0]   w_rank [NCH];
  logic [K*WL-1:0] w_sel_ped;
  logic [K*OW-1:0] w_sel_path;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_rank[i] = '0;
      for (int j = 0; j < NCH; j++) begin
        if ((r_ped[j] < r_ped[i]) || ((r_ped[j] == r_ped[i]) && (j < i))) begin
          w_rank[i] = w_rank[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel_ped  = '0;
    w_sel_path = '0;
    for (int r = 0; r < K; r++) begin
      for (int i = 0; i < NCH; i++) begin
        if (w_rank[i] == RW'(r)) begin
          w_sel_ped[r*WL +: WL]  = r_ped[i];
          w_sel_path[r*OW +: OW] = r_path[i];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: survivors
  // --------------------------------------------------------------------------
  logic [K*WL-1:0] r_ped_out;
  logic [K*OW-1:0] r_path_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ped_out  <= '0;
      r_path_out <= '0;
    end else begin
      r_ped_out  <= w_sel_ped;
      r_path_out <= w_sel_path;
    end
  end

  assign bus.PED_out  = r_ped_out;
  assign bus.PATH_out = r_path_out;

endmodule

// File: tb/tb_detector_stage.sv
// ----------------------------------------------------------------------------
// tb_detector_stage
// Directed vectors with hand-computed results, latency/reset checks and a
// streamed random run against an independent integer model (N=2).
// ----------------------------------------------------------------------------
module tb_detector_stage;
  import mimo_pkg::*;

  localparam int N       = 2;
  localparam int NR      = 1000;
  localparam int RST_CYC = 500;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  detector_stage_if #(.N(N)) bus ();

  detector_stage #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Current vector: R word0/word1, Y, parent codes and parent PEDs.
  int v_r0, v_r1, v_y;
  int v_path [K];
  int v_ped  [K];

  logic [15:0] e_path [NR+3];
  logic [63:0] e_ped  [NR+3];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.Rarr = {16'(v_r1), 16'(v_r0)};
    bus.Y    = 16'(v_y);
    for (int k = 0; k < K; k++) begin
      bus.PATH_in[k*2 +: 2]  = 2'(v_path[k]);
      bus.PED_in[k*16 +: 16] = 16'(v_ped[k]);
    end
  endtask

  task automatic set_all(input int r0, input int r1, input int y,
                         input int code, input int ped);
    v_r0 = r0; v_r1 = r1; v_y = y;
    for (int k = 0; k < K; k++) begin
      v_path[k] = code;
      v_ped[k]  = ped;
    end
  endtask

  // Integer reference: explicit arithmetic, then a stable selection sort.
  task automatic model(output logic [15:0] ep, output logic [63:0] ed);
    longint ped [NCH];
    bit     used [NCH];
    longint b, e, sq;
    int     best;
    for (int p = 0; p < K; p++) begin
      b = longint'(v_y) - longint'(v_r1) * sym_val(2'(v_path[p]));
      for (int c = 0; c < 4; c++) begin
        e  = b - longint'(v_r0) * sym_val(2'(c));
        sq = (e * e) / 1024;
        ped[p*4 + c] = longint'(v_ped[p]) + sq;
        if (ped[p*4 + c] > 65535) ped[p*4 + c] = 65535;
        used[p*4 + c] = 1'b0;
      end
    end
    ep = '0;
    ed = '0;
    for (int r = 0; r < K; r++) begin
      best = -1;
      for (int i = 0; i < NCH; i++) begin
        if (!used[i] && (best < 0 || ped[i] < ped[best])) best = i;
      end
      used[best] = 1'b1;
      ep[r*4 +: 4]   = {2'(v_path[best/4]), 2'(best%4)};
      ed[r*16 +: 16] = 16'(ped[best]);
    end
  endtask

  // Called right after a check (#1 past a rising edge): apply, hold 2 edges.
  task automatic apply_hold(input string tag, input logic [15:0] ep,
                            input logic [63:0] ed);
    drive();
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_path"}, 64'(bus.PATH_out), 64'(ep));
    check({tag, "_ped"},  bus.PED_out, ed);
  endtask

  task automatic rand_vec();
    bit big;
    big = ($urandom_range(0, 1) == 1);
    if (big) begin
      v_r0 = int'($urandom_range(0, 65535)) - 32768;
      v_r1 = int'($urandom_range(0, 65535)) - 32768;
      v_y  = int'($urandom_range(0, 65535)) - 32768;
    end else begin
      v_r0 = int'($urandom_range(0, 4095)) - 2048;
      v_r1 = int'($urandom_range(0, 4095)) - 2048;
      v_y  = int'($urandom_range(0, 8191)) - 4096;
    end
    for (int k = 0; k < K; k++) begin
      v_path[k] = int'($urandom_range(0, 3));
      v_ped[k]  = big ? int'($urandom_range(0, 65535))
                      : int'($urandom_range(0, 6000));
    end
  endtask

  initial begin
    set_all(0, 0, 0, 0, 0);
    drive();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_path", 64'(bus.PATH_out), 64'h0);
    check("reset_ped",  bus.PED_out, 64'h0);

    // Release reset together with case 1: valid after the second edge only.
    rst = 1'b0;
    set_all(1024, 0, 1024, 2, 0);
    v_ped[0] = 100; v_ped[1] = 200; v_ped[2] = 300; v_ped[3] = 400;
    drive();
    @(posedge clk); #1;
    check("lat_t1_path", 64'(bus.PATH_out), 64'h0);
    check("lat_t1_ped",  bus.PED_out, 64'h0);
    @(posedge clk); #1;
    check("lat_t2_path", 64'(bus.PATH_out), 64'hAAAA);
    check("lat_t2_ped",  bus.PED_out, 64'h0190_012C_00C8_0064);

    // b = -1.0, s=-1 cancels it: each parent's code 01 child has PED 0.
    set_all(1024, 1024, 0, 2, 0);
    apply_hold("c2", 16'h9999, 64'h0);

    // All zero: 16 ties, parent 0 codes 00..11 win.
    set_all(0, 0, 0, 0, 0);
    apply_hold("c3", 16'h3210, 64'h0);

    // Near-full PEDs: only exact-fit children stay below saturation.
    set_all(1024, 0, 1024, 2, 'hFFF0);
    apply_hold("c4a", 16'hAAAA, 64'hFFF0_FFF0_FFF0_FFF0);
    set_all(1024, 0, 3072, 2, 'hFFF0);
    apply_hold("c4b", 16'hBBBB, 64'hFFF0_FFF0_FFF0_FFF0);
    // Parent 0 at FFF0, others at FFFF: saturated FFFF ties fall to idx 0,1,2.
    set_all(1024, 0, 3072, 2, 'hFFFF);
    v_ped[0] = 'hFFF0;
    apply_hold("c4c", 16'hA98B, 64'hFFFF_FFFF_FFFF_FFF0);

    // Streamed random vectors, one per clock, with a one-edge reset mid-run.
    for (int cyc = 0; cyc < NR + 2; cyc++) begin
      @(posedge clk); #1;
      if (cyc >= 2) begin
        check($sformatf("rnd_path@%0d", cyc), 64'(bus.PATH_out), 64'(e_path[cyc]));
        check($sformatf("rnd_ped@%0d", cyc),  bus.PED_out, e_ped[cyc]);
      end
      if (cyc < NR) begin
        rand_vec();
        drive();
        model(e_path[cyc+2], e_ped[cyc+2]);
        if (cyc == RST_CYC) begin
          rst = 1'b1;
          e_path[cyc+1] = '0; e_ped[cyc+1] = '0;
          e_path[cyc+2] = '0; e_ped[cyc+2] = '0;
        end else begin
          rst = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
